// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state type
// CLK_FREQ / BAUD_RATE / DIVIDER: default clocking; state_t: receiver FSM states
package uart_pkg;
    localparam int CLK_FREQ  = 100_000_000;
    localparam int BAUD_RATE = 9600;
    localparam int DIVIDER   = CLK_FREQ / BAUD_RATE;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer with falling-edge detector for the RX line
// clk, rst (async, active-high): clocking; din: raw RX pin
// line: synchronized RX level; fall: one-cycle pulse on a synchronized 1->0 transition
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic line,
    output logic fall
);
    logic meta;
    logic prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            line <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            line <= meta;
            prev <= line;
        end
    end
    // prev must be high, so a line that stays low never fires again
    assign fall = prev & ~line;
endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver sampling mid-bit, LSB first
// clk, rst (async, active-high): clocking; din: serial RX line, idle high
// valid: level, high from a good stop bit until the next start edge; data: last good byte
module uart_recv #(
    parameter int CLK_FREQ  = uart_pkg::CLK_FREQ,
    parameter int BAUD_RATE = uart_pkg::BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       valid,
    output logic [7:0] data
);
    import uart_pkg::*;
    localparam int DIVIDER = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(DIVIDER);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVIDER / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVIDER - 1);
    logic          line;
    logic          fall;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic          valid_d;
    uart_sync sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .line (line),
        .fall (fall)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data    <= data_d;
            valid   <= valid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data;
        valid_d = valid;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_LAST) begin
                    // a line back high at mid start bit was only a glitch
                    state_d = line ? IDLE : DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // a low stop bit is a framing error: drop the byte
                    data_d  = line ? shift_q : data;
                    valid_d = line | valid;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: scoreboard bench for uart_recv at a reduced bit divider
module tb_uart_recv;
    import uart_pkg::*;
    localparam int CF  = 1_600_000;
    localparam int BR  = 100_000;
    localparam int D   = CF / BR;
    localparam int LAT = D / 2 + 9 * D + 3;
    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       valid;
    logic [7:0] data;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    logic       pv = 1'b0;
    logic [7:0] pd = 8'h00;
    uart_recv #(.CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .valid (valid),
        .data  (data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] b, input logic stop, input logic good, input logic peek);
        if (good) exp_q.push_back('{b, cyc});
        din = 1'b0;
        if (peek) begin
            repeat (4) @(negedge clk);
            chk("valid_cleared_on_start", {31'b0, valid}, 32'd0);
            repeat (D - 4) @(negedge clk);
        end else begin
            repeat (D) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            repeat (D) @(negedge clk);
        end
        din = stop;
        repeat (D) @(negedge clk);
        din = 1'b1;
    endtask
    always @(negedge clk) begin
        if (valid && !pv) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_valid observed=%0h expected=none", data);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", {24'b0, data}, {24'b0, e.b});
                chk("rx_latency_in_window", {31'b0, (cyc - e.t >= LAT - 1) && (cyc - e.t <= LAT + 1)}, 32'd1);
            end
        end
        if (valid && pv) chk("data_stable_while_valid", {24'b0, data}, {24'b0, pd});
        pv = valid;
        pd = data;
    end
    initial begin
        logic [7:0] bytes [10] = '{8'h55, 8'hA3, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'hFF, 8'h00, 8'h5A, 8'hA5};
        repeat (10) begin
            @(negedge clk);
            chk("reset_valid", {31'b0, valid}, 32'd0);
            chk("reset_data", {24'b0, data}, 32'd0);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_valid", {31'b0, valid}, 32'd0);
        chk("idle_data", {24'b0, data}, 32'd0);
        foreach (bytes[i]) send(bytes[i], 1'b1, 1'b1, 1'b0);
        repeat (D) @(negedge clk);
        chk("burst_all_received", exp_q.size(), 32'd0);
        chk("burst_last_data", {24'b0, data}, 32'hA5);
        din = 1'b0;
        repeat (3) @(negedge clk);
        din = 1'b1;
        repeat (2 * D) @(negedge clk);
        chk("glitch_valid", {31'b0, valid}, 32'd0);
        chk("glitch_state_idle", {30'b0, dut.state_q}, {30'b0, IDLE});
        send(8'h5A, 1'b1, 1'b1, 1'b0);
        repeat (D) @(negedge clk);
        chk("after_glitch_data", {24'b0, data}, 32'h5A);
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (D) @(negedge clk);
        chk("framing_valid", {31'b0, valid}, 32'd0);
        chk("framing_data_kept", {24'b0, data}, 32'h5A);
        send(8'h3C, 1'b1, 1'b1, 1'b0);
        repeat (D) @(negedge clk);
        chk("after_framing_valid", {31'b0, valid}, 32'd1);
        chk("after_framing_data", {24'b0, data}, 32'h3C);
        din = 1'b0;
        repeat (D) @(negedge clk);
        din = 1'b1;
        repeat (3 * D + D / 4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_valid", {31'b0, valid}, 32'd0);
        chk("async_reset_data", {24'b0, data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * D) @(negedge clk);
        chk("post_reset_valid", {31'b0, valid}, 32'd0);
        send(8'h81, 1'b1, 1'b1, 1'b0);
        repeat (D) @(negedge clk);
        chk("post_reset_data", {24'b0, data}, 32'h81);
        send(8'h33, 1'b1, 1'b1, 1'b0);
        repeat (5 * D) @(negedge clk);
        chk("hold_valid", {31'b0, valid}, 32'd1);
        chk("hold_data", {24'b0, data}, 32'h33);
        send(8'hC3, 1'b1, 1'b1, 1'b1);
        repeat (D) @(negedge clk);
        chk("final_data", {24'b0, data}, 32'hC3);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
